// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: Tnew/Tuse encodings,
// the in-flight write entry, and the saturating Tnew countdown helper.
package hazard_pkg;

    localparam int SB_REG_AW = 5;
    localparam int SB_TW     = 3;

    localparam logic [SB_TW-1:0] TNEW_NONE = 3'd0;
    localparam logic [SB_TW-1:0] TNEW_ALU  = 3'd1;
    localparam logic [SB_TW-1:0] TNEW_LOAD = 3'd2;
    localparam logic [SB_TW-1:0] TNEW_MFC0 = 3'd2;

    localparam logic [SB_TW-1:0] TUSE_BRANCH   = 3'd0;
    localparam logic [SB_TW-1:0] TUSE_ALU      = 3'd1;
    localparam logic [SB_TW-1:0] TUSE_STORE_RT = 3'd2;
    localparam logic [SB_TW-1:0] TUSE_NONE     = 3'd3;

    typedef struct packed {
        logic                 valid;
        logic [SB_REG_AW-1:0] dst;
        logic [SB_TW-1:0]     tnew;
        logic                 epc;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dst: 5'd0, tnew: 3'd0, epc: 1'b0};

    function automatic logic [SB_TW-1:0] tnew_dec(input logic [SB_TW-1:0] t);
        return (t == 3'd0) ? 3'd0 : (t - 3'd1);
    endfunction

    // Entry as it appears one stage further down the pipe.
    function automatic sb_entry_t entry_age(input sb_entry_t e);
        sb_entry_t r;
        r      = e;
        r.tnew = tnew_dec(e.tnew);
        return r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md_latency_counter.sv
// Multiply/divide latency counter: loads the op latency on issue and counts
// down to zero; busy is registered and rises the cycle after issue.
module md_latency_counter #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          busy_r;

    // Next count: reload on issue, otherwise count down to zero.
    always_comb begin
        cnt_next_s = cnt_r;
        if (load) begin
            cnt_next_s = is_div ? DIV_CNT : MULT_CNT;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_next_s = cnt_r - CNT_ONE;
        end else begin
            cnt_next_s = CNT_ZERO;
        end
    end

    // Counter and registered busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r  <= CNT_ZERO;
            busy_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            busy_r <= (cnt_next_s != CNT_ZERO);
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks in-flight GPR writes, mult/div latency and
// pending EPC writes, and raises stall. Optional macro: HAZARD_PERF_CNT_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = SB_REG_AW,
    parameter int TW         = SB_TW,
    parameter int MULT_LAT   = 5,
    parameter int DIV_LAT    = 10,
    parameter int EPC_ADDR   = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TW-1:0]     d_tuse_rs,
    input  logic [TW-1:0]     d_tuse_rt,
    input  logic              d_wen,
    input  logic [REG_AW-1:0] d_dst,
    input  logic [TW-1:0]     d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_hilo_use,
    input  logic              d_eret,
    input  logic              d_mtc0_epc,
    input  logic              flush,
    output logic              stall,
    output logic              md_busy,
    output logic [31:0]       stall_cycles
);

    localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
    localparam logic [TW-1:0]     TNEW_ZERO = {TW{1'b0}};

    sb_entry_t slot_r      [NUM_STAGES];
    sb_entry_t slot_next_s [NUM_STAGES];
    sb_entry_t new_entry_s;

    logic          rs_hit_s, rt_hit_s, epc_any_s;
    logic [TW-1:0] rs_tnew_s, rt_tnew_s;
    logic          rs_hz_s, rt_hz_s, hilo_hz_s, eret_hz_s;
    logic          stall_s, md_load_s, md_busy_s;

    // Youngest matching producer per source; scanning old-to-young lets the
    // lowest-index match overwrite any older one.
    always_comb begin
        rs_hit_s  = 1'b0;
        rt_hit_s  = 1'b0;
        rs_tnew_s = TNEW_ZERO;
        rt_tnew_s = TNEW_ZERO;
        epc_any_s = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            rs_tnew_s = (slot_r[i].valid && (slot_r[i].dst == d_rs)) ? slot_r[i].tnew : rs_tnew_s;
            rs_hit_s  = rs_hit_s | (slot_r[i].valid && (slot_r[i].dst == d_rs));
            rt_tnew_s = (slot_r[i].valid && (slot_r[i].dst == d_rt)) ? slot_r[i].tnew : rt_tnew_s;
            rt_hit_s  = rt_hit_s | (slot_r[i].valid && (slot_r[i].dst == d_rt));
            epc_any_s = epc_any_s | slot_r[i].epc;
        end
    end

    assign rs_hz_s   = (d_rs != REG_ZERO) && rs_hit_s && (rs_tnew_s > d_tuse_rs);
    assign rt_hz_s   = (d_rt != REG_ZERO) && rt_hit_s && (rt_tnew_s > d_tuse_rt);
    assign hilo_hz_s = d_hilo_use & md_busy_s;
    assign eret_hz_s = d_eret & epc_any_s;
    assign stall_s   = d_valid & (rs_hz_s | rt_hz_s | hilo_hz_s | eret_hz_s);
    assign stall     = stall_s;

    // The EPC flag is kept even for non-writing entries so eret sees mtc0.
    always_comb begin
        new_entry_s       = SB_EMPTY;
        new_entry_s.valid = d_valid & d_wen & (d_dst != REG_ZERO);
        new_entry_s.dst   = d_dst;
        new_entry_s.tnew  = d_tnew;
        new_entry_s.epc   = d_valid & d_mtc0_epc;
    end

    // Slot next state with priority flush > stall > advance.
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            slot_next_s[i] = slot_r[i];
        end
        if (flush) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                slot_next_s[i] = SB_EMPTY;
            end
        end else begin
            slot_next_s[0] = stall_s ? SB_EMPTY : new_entry_s;
            for (int i = 1; i < NUM_STAGES; i++) begin
                slot_next_s[i] = entry_age(slot_r[i-1]);
            end
        end
    end

    // Scoreboard slot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                slot_r[i] <= SB_EMPTY;
            end
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                slot_r[i] <= slot_next_s[i];
            end
        end
    end

    assign md_load_s = d_valid & d_md_start & ~flush & ~stall_s;

    md_latency_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (md_load_s),
        .is_div (d_md_div),
        .busy   (md_busy_s)
    );

    assign md_busy = md_busy_s;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_r;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_r <= 32'd0;
        end else if (stall_s && (perf_r != 32'hFFFF_FFFF)) begin
            perf_r <= perf_r + 32'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign stall_cycles = perf_r;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic [4:0]  d_rs, d_rt, d_dst;
    logic [2:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        d_wen, d_md_start, d_md_div, d_hilo_use, d_eret, d_mtc0_epc;
    logic        flush;
    logic        stall, md_busy;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;
    int exp_perf = 0;

    hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .d_valid      (d_valid),
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .d_tuse_rs    (d_tuse_rs),
        .d_tuse_rt    (d_tuse_rt),
        .d_wen        (d_wen),
        .d_dst        (d_dst),
        .d_tnew       (d_tnew),
        .d_md_start   (d_md_start),
        .d_md_div     (d_md_div),
        .d_hilo_use   (d_hilo_use),
        .d_eret       (d_eret),
        .d_mtc0_epc   (d_mtc0_epc),
        .flush        (flush),
        .stall        (stall),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_d();
        d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE;
        d_wen = 1'b0; d_dst = 5'd0; d_tnew = TNEW_NONE; d_md_start = 1'b0; d_md_div = 1'b0;
        d_hilo_use = 1'b0; d_eret = 1'b0; d_mtc0_epc = 1'b0; flush = 1'b0;
    endtask

    // One clock with the current D inputs: check outputs mid-cycle, then clock.
    task automatic cyc(input string tag, input logic exp_stall, input logic exp_busy);
        @(negedge clk);
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
        chk({tag, "_busy"}, {31'd0, md_busy}, {31'd0, exp_busy});
        @(posedge clk);
        if (exp_stall) exp_perf++;
        #1;
    endtask

    task automatic chk_perf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        chk(tag, stall_cycles, exp_perf);
`else
        chk(tag, stall_cycles, 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b0;
        clear_d();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_perf", stall_cycles, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // lw $8 then add using $8 (Tuse 1): one stall
        clear_d(); d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd8; d_tnew = TNEW_LOAD;
        cyc("lw_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_rs = 5'd8; d_tuse_rs = TUSE_ALU; d_wen = 1'b1; d_dst = 5'd10; d_tnew = TNEW_ALU;
        cyc("lw_use_stall", 1'b1, 1'b0);
        cyc("lw_use_go", 1'b0, 1'b0);

        // addi $9 then beq on $9 (rt=$10 already at Tnew 0): one stall
        clear_d(); d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd9; d_tnew = TNEW_ALU;
        cyc("addi_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_rs = 5'd9; d_tuse_rs = TUSE_BRANCH; d_rt = 5'd10; d_tuse_rt = TUSE_BRANCH;
        cyc("beq_stall", 1'b1, 1'b0);
        cyc("beq_go", 1'b0, 1'b0);

        // rt hazard, then store-data boundary (Tnew 2 not > Tuse 2)
        clear_d(); d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd12; d_tnew = TNEW_LOAD;
        cyc("lw12_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_rt = 5'd12; d_tuse_rt = TUSE_ALU;
        cyc("rt_stall", 1'b1, 1'b0);
        cyc("rt_go", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd13; d_tnew = TNEW_LOAD;
        cyc("lw13_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_rt = 5'd13; d_tuse_rt = TUSE_STORE_RT;
        cyc("sw_no_stall", 1'b0, 1'b0);

        // invalid D never stalls even with a hazard pattern present
        clear_d(); d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd14; d_tnew = TNEW_LOAD;
        cyc("lw14_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b0; d_rs = 5'd14; d_tuse_rs = TUSE_BRANCH;
        cyc("invalid_d", 1'b0, 1'b0);

        // youngest producer (Tnew 0) hides older load to the same register
        clear_d(); d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd31; d_tnew = TNEW_LOAD;
        cyc("lw31_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd31; d_tnew = TNEW_NONE;
        cyc("jal_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_rs = 5'd31; d_tuse_rs = TUSE_BRANCH;
        cyc("youngest_wins", 1'b0, 1'b0);

        // mult: busy 5 cycles, mflo stalls throughout, issues on the 6th
        clear_d(); d_valid = 1'b1; d_md_start = 1'b1; d_hilo_use = 1'b1;
        cyc("mult_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_hilo_use = 1'b1; d_wen = 1'b1; d_dst = 5'd2; d_tnew = TNEW_ALU;
        for (int i = 0; i < 5; i++) cyc("mult_wait", 1'b1, 1'b1);
        cyc("mflo_go_mult", 1'b0, 1'b0);

        // div: busy 10 cycles
        clear_d(); d_valid = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1; d_hilo_use = 1'b1;
        cyc("div_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_hilo_use = 1'b1; d_wen = 1'b1; d_dst = 5'd3; d_tnew = TNEW_ALU;
        for (int i = 0; i < 10; i++) cyc("div_wait", 1'b1, 1'b1);
        cyc("mflo_go_div", 1'b0, 1'b0);

        // mtc0 EPC then eret: two stall cycles
        clear_d(); d_valid = 1'b1; d_mtc0_epc = 1'b1;
        cyc("mtc0_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_eret = 1'b1;
        cyc("eret_stall1", 1'b1, 1'b0);
        cyc("eret_stall2", 1'b1, 1'b0);
        cyc("eret_go", 1'b0, 1'b0);
        chk_perf("perf_mid");

        // flush during a stall clears the load that would still block Tuse 0
        clear_d(); d_valid = 1'b1; d_wen = 1'b1; d_dst = 5'd5; d_tnew = TNEW_LOAD;
        cyc("lw5_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_rs = 5'd5; d_tuse_rs = TUSE_BRANCH; flush = 1'b1;
        cyc("flush_cycle", 1'b1, 1'b0);
        flush = 1'b0;
        cyc("after_flush", 1'b0, 1'b0);

        // flush suppresses a mult start
        clear_d(); d_valid = 1'b1; d_md_start = 1'b1; flush = 1'b1;
        cyc("mult_flushed", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_hilo_use = 1'b1;
        cyc("flush_blocks_md", 1'b0, 1'b0);
        chk_perf("perf_pre_reset");

        // async reset in the middle of a divide
        clear_d(); d_valid = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
        cyc("div2_issue", 1'b0, 1'b0);
        clear_d(); d_valid = 1'b1; d_hilo_use = 1'b1;
        @(negedge clk);
        chk("div2_wait_busy", {31'd0, md_busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        exp_perf = 0;
        chk("async_rst_busy", {31'd0, md_busy}, 32'd0);
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        chk_perf("async_rst_perf");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        cyc("post_reset", 1'b0, 1'b0);
        chk_perf("perf_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
